// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared FSM states and default sizing for the UART receive controller
package uart_ctrl_pkg;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TOUT_W_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UNLD = 2'd1,
        CAPT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: show-ahead byte FIFO with occupancy count; head reads as 0 when empty
module uart_byte_fifo
    import uart_ctrl_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          rxclk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    data,
    output logic [AW:0]   count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign wr_ok = push && (count != (AW+1)'(DEPTH));
    assign rd_ok = pop && (count != '0);
    assign data  = (count == '0) ? 8'h00 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

    // Storage needs no reset: the head is masked to 0 while empty
    always_ff @(posedge rxclk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: unloads bytes from a UART holding register into a FIFO and flags end-of-burst idles
module uart_rx_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter  int TOUT_W     = TOUT_W_DEF,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic              ctrl_en,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              uld_rx_data,
    output logic              rx_enable,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [TOUT_W-1:0] timeout_cycles,
    output logic              idle_tout,
    output logic [LW-1:0]     fifo_level
);

    rx_state_t         state;
    rx_state_t         state_nx;
    logic              full;
    logic              push;
    logic              pop;
    logic              armed;
    logic [TOUT_W-1:0] cnt;

    assign full      = fifo_level == LW'(FIFO_DEPTH);
    assign m_valid   = fifo_level != '0;
    assign pop       = m_valid && m_ready;
    assign idle_tout = armed && (timeout_cycles != '0) && (cnt == timeout_cycles);

    // State register
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and Moore outputs; a started unload always runs to capture
    always_comb begin
        state_nx    = IDLE;
        uld_rx_data = 1'b0;
        push        = 1'b0;
        case (state)
            IDLE: state_nx = (ctrl_en && !rx_empty && !full) ? UNLD : IDLE;
            UNLD: begin
                uld_rx_data = 1'b1;
                state_nx    = CAPT;
            end
            CAPT: push = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    // Receive enable follows the request one cycle late
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) rx_enable <= 1'b0;
        else       rx_enable <= ctrl_en;
    end

    // Idle counter: restarts on each write, stops on expiry or when disabled
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (push) begin
            cnt   <= '0;
            armed <= ctrl_en;
        end else if (!ctrl_en || idle_tout) begin
            armed <= 1'b0;
        end else if (armed && cnt != '1) begin
            cnt <= cnt + TOUT_W'(1);
        end
    end

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .rxclk (rxclk),
        .reset (reset),
        .push  (push),
        .din   (rx_data),
        .pop   (pop),
        .data  (m_data),
        .count (fifo_level)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench with UART model and scoreboard for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic        rxclk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_en = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        uld_rx_data;
    logic        rx_enable;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] timeout_cycles = 16'd10;
    logic        idle_tout;
    logic [2:0]  fifo_level;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int uld_cnt = 0;
    int tout_cnt = 0;
    int tout_cyc = 0;
    logic [7:0] uart_q[$];
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(.FIFO_DEPTH(4), .TOUT_W(16)) dut (
        .rxclk          (rxclk),
        .reset          (reset),
        .ctrl_en        (ctrl_en),
        .rx_empty       (rx_empty),
        .rx_data        (rx_data),
        .uld_rx_data    (uld_rx_data),
        .rx_enable      (rx_enable),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .timeout_cycles (timeout_cycles),
        .idle_tout      (idle_tout),
        .fifo_level     (fifo_level)
    );

    always #5 rxclk = ~rxclk;

    always @(posedge rxclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge rxclk);
    endtask

    task automatic offer(input logic [7:0] b);
        if (uart_q.size() == 0) rx_data = b;
        uart_q.push_back(b);
        rx_empty = 1'b0;
    endtask

    // UART holding register: hands over its byte when the unload strobe is seen
    initial forever begin
        @(negedge rxclk);
        if (uld_rx_data === 1'b1 && uart_q.size() != 0) begin
            rx_data  = uart_q.pop_front();
            rx_empty = (uart_q.size() == 0);
        end
    end

    // Monitor: scoreboards every accepted byte, counts strobes and timeout pulses
    initial forever begin
        @(negedge rxclk);
        #2;
        if (uld_rx_data === 1'b1) uld_cnt++;
        if (idle_tout === 1'b1) begin
            tout_cnt++;
            tout_cyc = cyc;
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no data", m_data);
            end else begin
                chk("pop_data", m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int wcyc;
        wait_cyc(2);
        chk("rst_uld", uld_rx_data, 0);
        chk("rst_rx_enable", rx_enable, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_idle_tout", idle_tout, 0);
        reset = 1'b0;
        wait_cyc(1);

        // single byte with latency and idle timeout of 10
        ctrl_en = 1'b1;
        base = uld_cnt;
        offer(8'hA5);
        exp_q.push_back(8'hA5);
        wait_cyc(1);
        chk("rx_enable_on", rx_enable, 1);
        chk("uld_high", uld_rx_data, 1);
        wait_cyc(1);
        chk("valid_not_early", m_valid, 0);
        wait_cyc(1);
        chk("valid_after_3", m_valid, 1);
        chk("head_a5", m_data, 8'hA5);
        chk("level_1", fifo_level, 1);
        chk("one_uld", uld_cnt - base, 1);
        wcyc = cyc;
        wait_cyc(14);
        chk("tout_once", tout_cnt, 1);
        chk("tout_delay", tout_cyc - wcyc, 10);
        m_ready = 1'b1;
        wait_cyc(1);
        m_ready = 1'b0;
        chk("level_0_after_pop", fifo_level, 0);

        // timeout disabled
        timeout_cycles = 16'd0;
        offer(8'h77);
        exp_q.push_back(8'h77);
        wait_cyc(20);
        chk("no_tout_when_0", tout_cnt, 1);
        m_ready = 1'b1;
        wait_cyc(2);
        m_ready = 1'b0;

        // fill to full, backpressure, then drain in order
        base = uld_cnt;
        for (int i = 1; i <= 5; i++) begin
            offer(8'(i));
            exp_q.push_back(8'(i));
        end
        wait_cyc(20);
        chk("full_level", fifo_level, 4);
        chk("full_uld4", uld_cnt - base, 4);
        chk("full_head", m_data, 8'h01);
        m_ready = 1'b1;
        wait_cyc(1);
        m_ready = 1'b0;
        wait_cyc(4);
        chk("refill_level", fifo_level, 4);
        chk("refill_uld5", uld_cnt - base, 5);
        m_ready = 1'b1;
        wait_cyc(6);
        chk("drain_level", fifo_level, 0);
        chk("drain_valid", m_valid, 0);
        m_ready = 1'b0;

        // simultaneous push and pop at level 2
        offer(8'h11);
        offer(8'h22);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        wait_cyc(8);
        chk("sim_level_2", fifo_level, 2);
        offer(8'h33);
        exp_q.push_back(8'h33);
        wait_cyc(2);
        chk("sim_capt_level", fifo_level, 2);
        m_ready = 1'b1;
        wait_cyc(1);
        m_ready = 1'b0;
        chk("sim_level_kept", fifo_level, 2);
        chk("sim_head_22", m_data, 8'h22);
        m_ready = 1'b1;
        wait_cyc(3);
        m_ready = 1'b0;
        chk("sim_drained", fifo_level, 0);

        // reset during unload discards the byte
        offer(8'hEE);
        wait_cyc(1);
        chk("unld_before_rst", uld_rx_data, 1);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_uld", uld_rx_data, 0);
        chk("mid_rst_rx_enable", rx_enable, 0);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_tout", idle_tout, 0);
        wait_cyc(1);
        reset = 1'b0;
        offer(8'h3C);
        exp_q.push_back(8'h3C);
        wait_cyc(3);
        chk("post_rst_valid", m_valid, 1);
        chk("post_rst_data", m_data, 8'h3C);
        chk("post_rst_level", fifo_level, 1);
        chk("post_rst_rx_enable", rx_enable, 1);
        m_ready = 1'b1;
        wait_cyc(1);
        m_ready = 1'b0;

        // ctrl_en dropped during capture
        timeout_cycles = 16'd8;
        base = tout_cnt;
        offer(8'h5A);
        exp_q.push_back(8'h5A);
        wait_cyc(2);
        chk("capt_no_uld", uld_rx_data, 0);
        ctrl_en = 1'b0;
        #1;
        chk("rx_enable_still_1", rx_enable, 1);
        wait_cyc(1);
        chk("drop_level", fifo_level, 1);
        chk("drop_data", m_data, 8'h5A);
        chk("rx_enable_off", rx_enable, 0);
        wcyc = uld_cnt;
        offer(8'h99);
        wait_cyc(15);
        chk("no_uld_disabled", uld_cnt - wcyc, 0);
        chk("drop_level_held", fifo_level, 1);
        chk("no_tout_disabled", tout_cnt - base, 0);
        m_ready = 1'b1;
        wait_cyc(2);
        m_ready = 1'b0;
        chk("end_level", fifo_level, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
